// File: rtl/seq_divider_8bit.sv
// Sequential restoring unsigned divider: one quotient bit per clock, start/busy/done handshake.
// Divide-by-zero completes after a single cycle with quotient all ones and remainder = dividend.
module seq_divider_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvs;

    logic [WIDTH:0]   p_shift;
    logic [WIDTH-1:0] p_sub;
    logic             fits;

    // The stored remainder is always below the divisor, so its top bit of the
    // WIDTH+1 bit partial remainder is implicitly zero and only exists in p_shift.
    always_comb begin
        p_shift = {p, q[WIDTH-1]};
        fits    = (p_shift >= {1'b0, dvs});
        p_sub   = p_shift[WIDTH-1:0] - dvs;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            p           <= '0;
            q           <= '0;
            dvs         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        q     <= dividend;
                        dvs   <= divisor;
                        p     <= '0;
                        cnt   <= '0;
                        busy  <= (divisor != '0);
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (dvs == '0) begin
                        // Zero divisor: q still holds the untouched dividend.
                        quotient    <= '1;
                        remainder   <= q;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= DONE;
                    end else if (cnt == LAST) begin
                        quotient    <= q;
                        remainder   <= p;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= DONE;
                    end else begin
                        p   <= fits ? p_sub : p_shift[WIDTH-1:0];
                        q   <= {q[WIDTH-2:0], fits};
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
